// File: rtl/filtro_rebote_multicanal_pkg.sv
// Shared constants and helpers for the multi-channel debounce block.
// Holds the single formula that turns clock rate and bounce time into a stable-sample count.
package filtro_pkg;

    localparam int MS_POR_S = 1000;
    localparam int DEB_MIN  = 1;

    function automatic int techo_log2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Stable samples required before the debounced level may change.
    function automatic int calc_deb(input int clk_hz, input int rebote_ms);
        int d;
        d = clk_hz / MS_POR_S * rebote_ms;
        return (d < DEB_MIN) ? DEB_MIN : d;
    endfunction

endpackage

// File: rtl/filtro_rebote_multicanal_if.sv
// Pin-side bundle of the debounce block: raw inputs in, debounced level, strobes and pulses out.
interface filtro_rebote_multicanal_if #(
    parameter int N_CANALES = 4
) ();

    logic [N_CANALES-1:0] pulso_real;
    logic [N_CANALES-1:0] estado;
    logic [N_CANALES-1:0] flanco_subida;
    logic [N_CANALES-1:0] flanco_bajada;
    logic [N_CANALES-1:0] pulso_ideal;

    modport master (
        output pulso_real,
        input  estado,
        input  flanco_subida,
        input  flanco_bajada,
        input  pulso_ideal
    );

    modport slave (
        input  pulso_real,
        output estado,
        output flanco_subida,
        output flanco_bajada,
        output pulso_ideal
    );

endinterface

// File: rtl/filtro_rebote_multicanal_canal.sv
// One debounce channel: 2-flop synchroniser, stable-time counter, debounced level,
// registered rise/fall strobes and a non-retriggerable fixed-length pulse on each press.
module filtro_rebote_canal
    import filtro_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int REBOTE_MS    = 2,
    parameter int PULSO_CICLOS = 1,
    parameter int ACTIVO_BAJO  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulso_real_i,
    output logic estado_o,
    output logic flanco_subida_o,
    output logic flanco_bajada_o,
    output logic pulso_ideal_o
);

    localparam int             DEB          = calc_deb(CLK_HZ, REBOTE_MS);
    localparam int             CW           = techo_log2(DEB + 1);
    localparam int             PW           = techo_log2(PULSO_CICLOS + 1);
    localparam logic [CW-1:0]  DEB_TOPE     = CW'(DEB - 1);
    localparam logic [PW-1:0]  PULSO_TOPE   = PW'(PULSO_CICLOS - 1);
    // Raw pin level that means "not pressed"; the synchroniser idles there.
    localparam logic           REPOSO_CRUDO = (ACTIVO_BAJO != 0);

    logic          sync1_q, sync2_q;
    logic          s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          estado_q, estado_d;
    logic          subida_q, subida_d;
    logic          bajada_q, bajada_d;
    logic          pulso_q, pulso_d;
    logic [PW-1:0] pcnt_q, pcnt_d;

    always_comb begin
        s        = sync2_q ^ REPOSO_CRUDO;
        cnt_d    = '0;
        estado_d = estado_q;
        if (s != estado_q) begin
            if (cnt_q == DEB_TOPE) begin
                estado_d = ~estado_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        subida_d = estado_d & ~estado_q;
        bajada_d = ~estado_d & estado_q;

        // A rise that lands while the pulse is running is dropped, not queued.
        pulso_d = pulso_q;
        pcnt_d  = pcnt_q;
        if (pulso_q) begin
            if (pcnt_q == '0) begin
                pulso_d = 1'b0;
            end else begin
                pcnt_d = pcnt_q - 1'b1;
            end
        end else if (subida_d) begin
            pulso_d = 1'b1;
            pcnt_d  = PULSO_TOPE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= REPOSO_CRUDO;
            sync2_q  <= REPOSO_CRUDO;
            cnt_q    <= '0;
            estado_q <= 1'b0;
            subida_q <= 1'b0;
            bajada_q <= 1'b0;
            pulso_q  <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            sync1_q  <= pulso_real_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
            subida_q <= subida_d;
            bajada_q <= bajada_d;
            pulso_q  <= pulso_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign estado_o        = estado_q;
    assign flanco_subida_o = subida_q;
    assign flanco_bajada_o = bajada_q;
    assign pulso_ideal_o   = pulso_q;

endmodule

// File: rtl/filtro_rebote_multicanal.sv
// N independent debounce channels behind one interface; each bit of the bus is its own channel.
module filtro_rebote_multicanal
    import filtro_pkg::*;
#(
    parameter int N_CANALES    = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int REBOTE_MS    = 2,
    parameter int PULSO_CICLOS = 1,
    parameter int ACTIVO_BAJO  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    filtro_rebote_multicanal_if.slave  bus
);

    logic [N_CANALES-1:0] estado_w;
    logic [N_CANALES-1:0] subida_w;
    logic [N_CANALES-1:0] bajada_w;
    logic [N_CANALES-1:0] pulso_w;

    for (genvar gi = 0; gi < N_CANALES; gi++) begin : g_canal
        filtro_rebote_canal #(
            .CLK_HZ       (CLK_HZ),
            .REBOTE_MS    (REBOTE_MS),
            .PULSO_CICLOS (PULSO_CICLOS),
            .ACTIVO_BAJO  (ACTIVO_BAJO)
        ) u_canal (
            .clk             (clk),
            .rst_n           (rst_n),
            .pulso_real_i    (bus.pulso_real[gi]),
            .estado_o        (estado_w[gi]),
            .flanco_subida_o (subida_w[gi]),
            .flanco_bajada_o (bajada_w[gi]),
            .pulso_ideal_o   (pulso_w[gi])
        );
    end

    assign bus.estado        = estado_w;
    assign bus.flanco_subida = subida_w;
    assign bus.flanco_bajada = bajada_w;
    assign bus.pulso_ideal   = pulso_w;

endmodule

// File: tb/tb_filtro_rebote_multicanal.sv
// Directed bench: dut_a is the reference build (DEB=4, 3-cycle pulse, active-high),
// dut_b the active-low 10-cycle build, dut_c a DEB=1 10-cycle build used for the retrigger case.
module tb_filtro_rebote_multicanal;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    filtro_rebote_multicanal_if #(.N_CANALES(N)) bus_a ();
    filtro_rebote_multicanal_if #(.N_CANALES(N)) bus_b ();
    filtro_rebote_multicanal_if #(.N_CANALES(N)) bus_c ();

    filtro_rebote_multicanal #(
        .N_CANALES(N), .CLK_HZ(1000), .REBOTE_MS(4), .PULSO_CICLOS(3), .ACTIVO_BAJO(0)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    filtro_rebote_multicanal #(
        .N_CANALES(N), .CLK_HZ(1000), .REBOTE_MS(4), .PULSO_CICLOS(10), .ACTIVO_BAJO(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    filtro_rebote_multicanal #(
        .N_CANALES(N), .CLK_HZ(1000), .REBOTE_MS(1), .PULSO_CICLOS(10), .ACTIVO_BAJO(0)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int n_checks = 0;
    int n_errors = 0;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
        end else begin
            $display("chk  %s: %0h", tag, obs);
        end
    endtask

    // Inputs are driven, and outputs read, 1 time unit after the rising edge.
    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] rebote;

    initial begin
        rst_n            = 1'b0;
        bus_a.pulso_real = 4'hF;
        bus_b.pulso_real = 4'hF;
        bus_c.pulso_real = 4'h0;
        rebote           = 9'b111101101;

        // T1: outputs held at 0 during reset even with inputs active, then one clean rise.
        repeat (3) paso();
        comprobar("T1 rst estado_a", 32'(bus_a.estado), 32'h0);
        comprobar("T1 rst subida_a", 32'(bus_a.flanco_subida), 32'h0);
        comprobar("T1 rst pulso_a",  32'(bus_a.pulso_ideal), 32'h0);
        comprobar("T1 rst estado_b", 32'(bus_b.estado), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            paso();
            comprobar($sformatf("T1 estado k=%0d", k), 32'(bus_a.estado), (k >= 6) ? 32'hF : 32'h0);
            comprobar($sformatf("T1 subida k=%0d", k), 32'(bus_a.flanco_subida), (k == 6) ? 32'hF : 32'h0);
            comprobar($sformatf("T1 pulso k=%0d", k), 32'(bus_a.pulso_ideal),
                      (k >= 6 && k <= 8) ? 32'hF : 32'h0);
        end
        comprobar("T1 idle estado_b", 32'(bus_b.estado), 32'h0);
        comprobar("T1 idle estado_c", 32'(bus_c.estado), 32'h0);
        bus_a.pulso_real = 4'h0;
        repeat (12) paso();
        comprobar("T1 released estado", 32'(bus_a.estado), 32'h0);

        // T2: clean press on ch0.
        bus_a.pulso_real = 4'h1;
        for (int k = 1; k <= 9; k++) begin
            paso();
            comprobar($sformatf("T2 estado k=%0d", k), 32'(bus_a.estado), (k >= 6) ? 32'h1 : 32'h0);
            comprobar($sformatf("T2 subida k=%0d", k), 32'(bus_a.flanco_subida), (k == 6) ? 32'h1 : 32'h0);
            comprobar($sformatf("T2 pulso k=%0d", k), 32'(bus_a.pulso_ideal),
                      (k >= 6 && k <= 8) ? 32'h1 : 32'h0);
        end
        repeat (11) paso();
        comprobar("T2 held estado", 32'(bus_a.estado), 32'h1);

        // T3: bouncing ch1; only the trailing run of four 1s counts.
        for (int t = 0; t < 12; t++) begin
            bus_a.pulso_real = {2'b00, (t < 9) ? rebote[t] : 1'b1, 1'b1};
            paso();
            comprobar($sformatf("T3 estado k=%0d", t + 1), 32'(bus_a.estado),
                      (t + 1 >= 11) ? 32'h3 : 32'h1);
            comprobar($sformatf("T3 subida k=%0d", t + 1), 32'(bus_a.flanco_subida),
                      (t + 1 == 11) ? 32'h2 : 32'h0);
        end
        repeat (5) paso();

        // T4: 3-cycle glitch on ch2 never gets through.
        for (int t = 0; t < 10; t++) begin
            bus_a.pulso_real = (t < 3) ? 4'h7 : 4'h3;
            paso();
            comprobar($sformatf("T4 ch2 k=%0d", t + 1),
                      32'({bus_a.estado[2], bus_a.flanco_subida[2], bus_a.pulso_ideal[2]}), 32'h0);
        end
        comprobar("T4 estado", 32'(bus_a.estado), 32'h3);

        // T5: release ch0 and press ch3 in the same cycle.
        bus_a.pulso_real = 4'hA;
        for (int k = 1; k <= 7; k++) begin
            paso();
            comprobar($sformatf("T5 bajada k=%0d", k), 32'(bus_a.flanco_bajada), (k == 6) ? 32'h1 : 32'h0);
            comprobar($sformatf("T5 subida k=%0d", k), 32'(bus_a.flanco_subida), (k == 6) ? 32'h8 : 32'h0);
            comprobar($sformatf("T5 estado k=%0d", k), 32'(bus_a.estado), (k >= 6) ? 32'hA : 32'h3);
        end

        // T7: asynchronous reset mid-operation, then fresh re-debounce of the held inputs.
        rst_n = 1'b0;
        #2;
        comprobar("T7 async estado", 32'(bus_a.estado), 32'h0);
        comprobar("T7 async pulso", 32'(bus_a.pulso_ideal), 32'h0);
        paso();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            paso();
            comprobar($sformatf("T7 subida k=%0d", k), 32'(bus_a.flanco_subida), (k == 6) ? 32'hA : 32'h0);
            comprobar($sformatf("T7 pulso k=%0d", k), 32'(bus_a.pulso_ideal), (k >= 6) ? 32'hA : 32'h0);
        end

        // T6a: active-low build, 0 on ch0 is a press; 10-cycle pulse.
        bus_b.pulso_real = 4'hE;
        for (int k = 1; k <= 17; k++) begin
            paso();
            comprobar($sformatf("T6 estado_b k=%0d", k), 32'(bus_b.estado), (k >= 6) ? 32'h1 : 32'h0);
            comprobar($sformatf("T6 subida_b k=%0d", k), 32'(bus_b.flanco_subida), (k == 6) ? 32'h1 : 32'h0);
            comprobar($sformatf("T6 pulso_b k=%0d", k), 32'(bus_b.pulso_ideal),
                      (k >= 6 && k <= 15) ? 32'h1 : 32'h0);
        end

        // T6b: press/release/press inside one pulse (DEB=1) gives a single 10-cycle pulse.
        for (int t = 0; t < 20; t++) begin
            bus_c.pulso_real = (t == 4 || t == 5) ? 4'h0 : 4'h1;
            paso();
            comprobar($sformatf("T6 estado_c k=%0d", t + 1), 32'(bus_c.estado),
                      ((t + 1 >= 3 && t + 1 <= 6) || t + 1 >= 9) ? 32'h1 : 32'h0);
            comprobar($sformatf("T6 subida_c k=%0d", t + 1), 32'(bus_c.flanco_subida),
                      (t + 1 == 3 || t + 1 == 9) ? 32'h1 : 32'h0);
            comprobar($sformatf("T6 bajada_c k=%0d", t + 1), 32'(bus_c.flanco_bajada),
                      (t + 1 == 7) ? 32'h1 : 32'h0);
            comprobar($sformatf("T6 pulso_c k=%0d", t + 1), 32'(bus_c.pulso_ideal),
                      (t + 1 >= 3 && t + 1 <= 12) ? 32'h1 : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/filtro_rebote_multicanal.md
Name: filtro_rebote_multicanal

Overview:
- Parametrised N-channel successor to the single-input debounce/pulse block used for board push-buttons and switches.
- Per channel: 2-flop synchroniser, stable-time debounce filter, debounced level output, one-cycle rise/fall strobes, and a fixed-length one-shot pulse on each debounced press.
- Sits between the board input pins and the control FSMs. Replaces per-button instances with a single block.

Parameters:
- N_CANALES, 4, number of independent input channels (≥1).
- CLK_HZ, 50_000_000, clock frequency in Hz.
- REBOTE_MS, 2, required stable time in ms. DEB = CLK_HZ/1000*REBOTE_MS, clamped to a minimum of 1.
- PULSO_CICLOS, 1, length of the one-shot pulso_ideal in clock cycles (≥1).
- ACTIVO_BAJO, 1, when 1 each raw input is inverted after synchronisation, so a pressed active-low key reads as 1.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pulso_real, input, N_CANALES, raw asynchronous inputs, bit i = channel i.
- estado, output, N_CANALES, debounced level per channel.
- flanco_subida, output, N_CANALES, one-cycle strobe on each debounced 0→1 transition.
- flanco_bajada, output, N_CANALES, one-cycle strobe on each debounced 1→0 transition.
- pulso_ideal, output, N_CANALES, PULSO_CICLOS-cycle one-shot on each debounced press.

Behaviour:
- Reset (rst_n=0, asynchronous): synchroniser flops, counters, estado, flanco_*, pulso_ideal and pulse counters all go to 0. Synchroniser flops reset to the logical inactive level after polarity.
- Synchroniser: 2 flops per channel, then optional inversion. s_i denotes the synchronised, polarity-corrected input.
- Debounce counter: width $clog2(DEB+1), one per channel.
  - s_i == estado[i]: counter clears to 0.
  - s_i != estado[i] and counter < DEB-1: counter increments.
  - s_i != estado[i] and counter == DEB-1: estado[i] toggles on the next edge and the counter clears.
  - Net effect: estado changes only after DEB consecutive differing samples. Any single agreeing sample restarts the count.
- Latency: a clean raw edge reaches estado after 2 + DEB clock edges (±1 for input sampling phase).
- Strobes:
  - flanco_subida[i] is high exactly during the first cycle in which estado[i] = 1.
  - flanco_bajada[i] is high exactly during the first cycle in which estado[i] = 0 after being 1.
  - Both strobes are registered, never combinational from the pins, and never high simultaneously on the same channel.
- One-shot:
  - pulso_ideal[i] rises in the same cycle as flanco_subida[i] and stays high for exactly PULSO_CICLOS cycles.
  - A new debounced rise while the pulse is active is ignored: no retrigger, no extension.
  - A debounced fall during the pulse does not truncate it.
- Channels are fully independent. Simultaneous events on different channels are handled in the same cycle with no interaction.
- Reset mid-operation: everything clears immediately. If the input is still held active when rst_n releases, the channel re-debounces from scratch and produces a fresh flanco_subida and pulso_ideal after 2 + DEB cycles.
- Counters never wrap, because the count is bounded by DEB-1.
- DEB = 1 degenerates to a plain 2-flop synchroniser plus edge detector.

Decomposition:
- Package filtro_pkg holds:
  - a ceil-log2 helper function;
  - constants MS_POR_S = 1000 and DEB_MIN = 1;
  - the DEB computation, so the top level and tests share one formula.
- One sub-module, filtro_rebote_canal. It implements a single channel (synchroniser, counter, estado, strobes, one-shot) with the same parameters minus N_CANALES.
- The top level is a generate loop over N_CANALES instances.

Test Plan:
- All tests use CLK_HZ=1000, REBOTE_MS=4 (DEB=4), PULSO_CICLOS=3, ACTIVO_BAJO=0, N_CANALES=4.
- T1 Reset: hold rst_n=0 with pulso_real=4'hF, then release → all outputs 0 during reset. estado=4'hF after 6 cycles, with a single flanco_subida=4'hF and pulso_ideal=4'hF for 3 cycles.
- T2 Clean press on ch0, held 20 cycles → estado[0] rises 6 cycles after the input. flanco_subida[0] is high 1 cycle. pulso_ideal[0] is high 3 cycles. Other channels stay 0.
- T3 Bounce: ch1 toggles 1,0,1,1,0,1,1,1,1 per cycle → estado[1] rises only after the final 4 consecutive 1s. No strobe before that.
- T4 Glitch: 3-cycle high on ch2 → estado, flanco_subida and pulso_ideal on ch2 stay 0 throughout.
- T5 Release plus independence: release ch0 while pressing ch3 in the same cycle → flanco_bajada[0] and flanco_subida[3] occur in the same cycle, 6 cycles later.
- T6 Polarity and retrigger:
  - Rebuild with ACTIVO_BAJO=1, pulso_real idle=4'hF; a 0 on ch0 → estado[0]=1 after 6 cycles.
  - With PULSO_CICLOS=10, press/release/press within 10 cycles → only one 10-cycle pulso_ideal.
